// File: rtl/rr_grant_arbiter.sv
// Registered round-robin grant arbiter with a locked one-hot grant held until release.
// RR_GRANT_ARBITER_ROTATE_EN selects rotating priority; when undefined, the arbiter uses fixed lowest-index priority.
module rr_grant_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] req_i,
  input  logic             release_i,
  output logic [WIDTH-1:0] grant_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] last_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] pick;

  // Isolates the lowest set bit with the two's-complement trick.
  function automatic logic [WIDTH-1:0] first_set(input logic [WIDTH-1:0] v);
    return v & (~v + WIDTH'(1));
  endfunction

`ifdef RR_GRANT_ARBITER_ROTATE_EN
  logic [WIDTH-1:0] last_shl;
  logic [WIDTH-1:0] hi_mask;
  logic [WIDTH-1:0] hi_req;

  // When last is the top bit, the shift truncates to 0, the mask becomes all ones, and the search wraps to index 0.
  assign last_shl = last_q << 1;
  assign hi_mask  = (last_shl - WIDTH'(1)) | last_q;
  assign hi_req   = req_i & ~hi_mask;
  assign pick     = (hi_req != '0) ? first_set(hi_req) : first_set(req_i);
`else
  assign pick = first_set(req_i);
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req_i != '0) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (release_i) begin
          grant_d = '0;
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == BUSY);
  assign last_o  = last_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: directed steps push the expected post-edge outputs, and a monitor compares them on the falling edge.
module tb_rr_grant_arbiter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] req = '0;
  logic         rel = 1'b0;
  logic [W-1:0] grant;
  logic         busy;
  logic [W-1:0] last;

  typedef struct packed {
    logic [W-1:0] grant;
    logic         busy;
    logic [W-1:0] last;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  rr_grant_arbiter #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .req_i     (req),
    .release_i (rel),
    .grant_o   (grant),
    .busy_o    (busy),
    .last_o    (last)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs and queues the outputs expected after that edge.
  // Expectations are given for both the rotating build and the fixed-priority build.
  task automatic step(input logic r, input logic [W-1:0] rq, input logic rl,
                      input logic b,
                      input logic [W-1:0] g_rr, input logic [W-1:0] l_rr,
                      input logic [W-1:0] g_fx, input logic [W-1:0] l_fx);
    exp_t e;
    reset = r;
    req   = rq;
    rel   = rl;
    e.busy = b;
`ifdef RR_GRANT_ARBITER_ROTATE_EN
    e.grant = g_rr;
    e.last  = l_rr;
`else
    e.grant = g_fx;
    e.last  = l_fx;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!$onehot0(grant)) begin
      miscompares++;
      $display("FAIL onehot: grant=%b is multi-hot", grant);
    end
    if ((grant != '0) != busy) begin
      miscompares++;
      $display("FAIL busy_vs_grant: busy=%b grant=%b", busy, grant);
    end
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (grant !== e.grant || busy !== e.busy || last !== e.last) begin
        miscompares++;
        $display("FAIL vec%0d: got grant=%b busy=%b last=%b, expected grant=%b busy=%b last=%b",
                 vectors, grant, busy, last, e.grant, e.busy, e.last);
      end
    end
  end

  initial begin
    @(negedge clk);
    #1;
    //    rst  req      rel busy g_rr     l_rr     g_fx     l_fx
    step(1, 4'b0000, 0, 0, 4'b0000, 4'b1000, 4'b0000, 4'b1000);
    step(0, 4'b0110, 0, 1, 4'b0010, 4'b1000, 4'b0010, 4'b1000);
    step(0, 4'b0110, 0, 1, 4'b0010, 4'b1000, 4'b0010, 4'b1000);
    step(0, 4'b0110, 1, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
    step(0, 4'b0110, 0, 1, 4'b0100, 4'b0010, 4'b0010, 4'b0010);
    for (int i = 0; i < 5; i++)
      step(0, 4'b0000, 0, 1, 4'b0100, 4'b0010, 4'b0010, 4'b0010);
    step(0, 4'b0000, 1, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0010);
    step(0, 4'b0000, 0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0010);
    step(0, 4'b0110, 1, 1, 4'b0010, 4'b0100, 4'b0010, 4'b0010);
    step(0, 4'b0000, 1, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
    step(0, 4'b0110, 0, 1, 4'b0100, 4'b0010, 4'b0010, 4'b0010);
    step(1, 4'b1111, 0, 0, 4'b0000, 4'b1000, 4'b0000, 4'b1000);
    step(0, 4'b1111, 0, 1, 4'b0001, 4'b1000, 4'b0001, 4'b1000);
    step(0, 4'b1001, 1, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
    step(0, 4'b1001, 0, 1, 4'b1000, 4'b0001, 4'b0001, 4'b0001);
    step(0, 4'b1001, 1, 0, 4'b0000, 4'b1000, 4'b0000, 4'b0001);
    step(0, 4'b1001, 0, 1, 4'b0001, 4'b1000, 4'b0001, 4'b0001);
    step(0, 4'b0000, 1, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
    step(0, 4'b1000, 0, 1, 4'b1000, 4'b0001, 4'b1000, 4'b0001);
    step(0, 4'b1000, 1, 0, 4'b0000, 4'b1000, 4'b0000, 4'b1000);
    step(0, 4'b1000, 0, 1, 4'b1000, 4'b1000, 4'b1000, 4'b1000);
    step(0, 4'b0110, 1, 0, 4'b0000, 4'b1000, 4'b0000, 4'b1000);
    req = '0;
    rel = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Registered round-robin arbiter: samples a request vector, picks exactly one requester with a rotating lowest-index-first search, and holds a one-hot grant until the winner signals release. It sits downstream of the one-hot first-set-bit selector. It feeds the selector a masked request vector and consumes the one-hot winner, turning a purely combinational pick into a locked, fair grant. Its users are the shared-resource ports: memory bus, writeback, and the fetch/LSU queues.

## Interface
- WIDTH, 4: number of requesters; must be ≥2.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  WIDTH  request vector; bit i = requester i wants the resource.
- release  in  1  current grant holder is done; meaningful only while busy=1.
- grant  out  WIDTH  registered one-hot grant; all-zero when idle.
- busy  out  1  registered; 1 while a grant is held (equals |grant).
- last  out  WIDTH  registered one-hot index of the most recent winner (debug/perf).

## Operation
- States: IDLE (busy=0), BUSY (busy=1). State is a single flop; grant/last are WIDTH-bit flop banks.
- Candidate vector:
  - hi_req = req & ~(((last<<1) - 1) | last) masked to WIDTH bits, i.e. requests at indices strictly above last.
  - pick = lowest set bit of hi_req if hi_req≠0, else lowest set bit of req.
  - Both lowest-bit searches use the shared first-set-bit selector (lowest index wins).
- IDLE, req≠0: next edge grant<=pick, busy<=1, state<=BUSY.
- IDLE, req=0: grant stays 0, state stays IDLE.
- BUSY: grant is locked. Changes on req (including the holder dropping its bit) are ignored.
- BUSY, release=1: next edge grant<=0, busy<=0, last<=grant, state<=IDLE.
- release in IDLE is ignored.
- Wrap-around: last=bit WIDTH-1 gives hi_req=0, so the search restarts at index 0.
- grant is never multi-hot and never nonzero in IDLE. The bench asserts both every cycle.

## Timing
- Reset values: grant=0, busy=0, state=IDLE, last=bit WIDTH-1 (one-hot), so the first arbitration favours index 0.
- Reset has priority over all other inputs, including mid-grant. A grant active at reset clears on that edge.
- Request-to-grant latency: 1 cycle. req sampled in IDLE at edge N produces grant visible after edge N.
- Release-to-idle: 1 cycle. There is always one IDLE cycle between consecutive grants. Minimum period per grant is 2 cycles with release asserted in the first BUSY cycle.
- Simultaneous release and new requests in BUSY: release wins. New requests are arbitrated in the following IDLE cycle using the updated last.
- All outputs come straight from flops; there is no combinational path from req/release to any output.

## Configuration
- RR_GRANT_ARBITER_ROTATE_EN defined: round-robin as described. last feeds the hi_req mask.
- Not defined: fixed priority. pick = lowest set bit of req, and the hi_req path is not built. last is still registered and updated for debug.

## Test plan
- WIDTH=4, reset, req=4'b0110 → after 1 edge grant=4'b0010, busy=1; last=4'b1000 until release.
- Hold req=4'b0110, pulse release in BUSY → grant=0 for one cycle with last=4'b0010, then grant=4'b0100 (rotation).
- last=4'b1000, req=4'b1001 → grant=4'b0001 (wrap); with req=4'b1000 only → grant=4'b1000.
- In BUSY with grant=4'b0100, drop req to 0 for 5 cycles with no release → grant stays 4'b0100, busy=1.
- Macro undefined, req=4'b0110 held with repeated releases → every grant=4'b0010.
- Assert reset while grant=4'b0100 → next edge grant=0, busy=0, last=4'b1000. The next req=4'b1111 then grants 4'b0001.
